// File: rtl/slave_port.sv
`default_nettype none
// ============================================================================
// Module   : slave_port
// Purpose  : Slave-side endpoint of the serial system bus. Deserialises the
//            request stream (address, burst length, write data), performs
//            single or burst accesses on a local word memory and serialises
//            read words back under a valid/ready handshake.
// Options  : define SLAVE_PORT_PARITY_EN to expect an even-parity beat after
//            every write word; bad words are dropped and parity_err is set.
// Revision : 1.0 - initial release
// ============================================================================
module slave_port #(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic master_valid,
  input  logic master_ready,
  input  logic read_en,
  input  logic write_en,
  input  logic tx_address,
  input  logic tx_data,
  input  logic tx_burst,
  output logic slave_ready,
  output logic slave_valid,
  output logic rx_data,
  output logic parity_err
);

  // Beats per write word: data bits, plus one parity beat when enabled.
`ifdef SLAVE_PORT_PARITY_EN
  localparam int WBEATS = DATA_WIDTH + 1;
`else
  localparam int WBEATS = DATA_WIDTH;
`endif
  localparam int CNT_MAX = (ADDR_WIDTH > WBEATS) ? ADDR_WIDTH : WBEATS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      ADDR_LAST   = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      DATA_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]      BURST_BEATS = CNT_W'(BURST_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] WORDS_ONE  = BURST_WIDTH'(1);
`ifdef SLAVE_PORT_PARITY_EN
  localparam logic [CNT_W-1:0]      PARITY_BEAT = CNT_W'(DATA_WIDTH);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_RFETCH = 3'd3,
    S_RDATA  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [BURST_WIDTH-1:0]  words_q, words_d;   // words remaining minus one
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;   // write assembly / read serialiser
  logic                    is_wr_q, is_wr_d;
  logic                    perr_q,  perr_d;

  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    word_done;

  // Local word memory; deliberately not reset so contents survive rst.
  logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      shift_q <= '0;
      is_wr_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      shift_q <= shift_d;
      is_wr_q <= is_wr_d;
      perr_q  <= perr_d;
    end
  end

  // Memory write port; a word is only committed on its final beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  // Next-state and datapath control for the request/response sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    shift_d   = shift_q;
    is_wr_d   = is_wr_q;
    perr_d    = perr_q;
    mem_we    = 1'b0;
    mem_wdata = shift_q;
    word_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The starting beat doubles as address bit 0 and burst bit 0.
        if (master_valid && (read_en ^ write_en)) begin
          is_wr_d = write_en;
          addr_d  = {tx_address, addr_q[ADDR_WIDTH-1:1]};
          words_d = (words_q >> 1) | (BURST_WIDTH'(tx_burst) << (BURST_WIDTH - 1));
          cnt_d   = CNT_ONE;
          perr_d  = 1'b0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (master_valid) begin
          addr_d = {tx_address, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q < BURST_BEATS) begin
            words_d = (words_q >> 1) | (BURST_WIDTH'(tx_burst) << (BURST_WIDTH - 1));
          end
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = is_wr_q ? S_WDATA : S_RFETCH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_WDATA: begin
        if (master_valid) begin
`ifdef SLAVE_PORT_PARITY_EN
          if (cnt_q != PARITY_BEAT) begin
            shift_d = {tx_data, shift_q[DATA_WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_ONE;
          end else begin
            // Even parity: the parity beat equals the XOR of the word.
            word_done = 1'b1;
            mem_wdata = shift_q;
            if (tx_data == ^shift_q) begin
              mem_we = ~rst;
            end else begin
              perr_d = 1'b1;
            end
          end
`else
          shift_d = {tx_data, shift_q[DATA_WIDTH-1:1]};
          if (cnt_q == DATA_LAST) begin
            word_done = 1'b1;
            mem_wdata = shift_d;
            mem_we    = ~rst;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`endif
          if (word_done) begin
            addr_d = addr_q + ADDR_ONE;
            cnt_d  = '0;
            if (words_q == '0) begin
              state_d = S_IDLE;
            end else begin
              words_d = words_q - WORDS_ONE;
            end
          end
        end
      end

      S_RFETCH: begin
        shift_d = mem[addr_q];
        addr_d  = addr_q + ADDR_ONE;
        cnt_d   = '0;
        state_d = S_RDATA;
      end

      S_RDATA: begin
        if (master_ready) begin
          shift_d = shift_q >> 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (words_q == '0) begin
              state_d = S_IDLE;
            end else begin
              words_d = words_q - WORDS_ONE;
              state_d = S_RFETCH;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; no input reaches an output.
  assign slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign slave_valid = (state_q == S_RDATA);
  assign rx_data     = (state_q == S_RDATA) & shift_q[0];

`ifdef SLAVE_PORT_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_port
// Purpose  : Self-checking bench for slave_port. Read tasks push expected
//            rx_data bits into a scoreboard queue; a monitor pops and
//            compares on every accepted read bit. Timing is checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_port;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int BW = 2;

  typedef logic [DW-1:0] word_arr_t [4];

  logic clk = 1'b0;
  logic rst;
  logic master_valid, master_ready, read_en, write_en;
  logic tx_address, tx_data, tx_burst;
  logic slave_ready, slave_valid, rx_data, parity_err;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  slave_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BURST_WIDTH(BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .master_valid(master_valid),
    .master_ready(master_ready),
    .read_en     (read_en),
    .write_en    (write_en),
    .tx_address  (tx_address),
    .tx_data     (tx_data),
    .tx_burst    (tx_burst),
    .slave_ready (slave_ready),
    .slave_valid (slave_valid),
    .rx_data     (rx_data),
    .parity_err  (parity_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every bit the master accepts must match the queue head.
  always @(negedge clk) begin
    if (!rst && slave_valid && master_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected actual=%0b required=no_bit t=%0t", rx_data, $time);
      end else begin
        chk("rx_bit", {31'd0, rx_data}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    master_valid = 1'b0;
    read_en      = 1'b0;
    write_en     = 1'b0;
    tx_address   = 1'b0;
    tx_data      = 1'b0;
    tx_burst     = 1'b0;
  endtask

  // Address phase; burst bits ride on the first BW beats, junk after that.
  task automatic send_addr(input bit is_rd, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input bit gaps);
    for (int i = 0; i < AW; i++) begin
      if (gaps && i > 0 && (i % 3 == 0)) begin
        master_valid = 1'b0;
        tx_address   = ~a[i];
        tx_burst     = 1'b1;
        cyc();
      end
      master_valid = 1'b1;
      read_en      = (i == 0) && is_rd;
      write_en     = (i == 0) && !is_rd;
      tx_address   = a[i];
      tx_burst     = (i < BW) ? b[i] : 1'b1;
      cyc();
    end
    quiet();
  endtask

  task automatic write_words(input logic [AW-1:0] a, input int n, input word_arr_t w,
                             input bit gaps, input bit bad_par);
    send_addr(1'b0, a, BW'(n - 1), gaps);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < DW; j++) begin
        if (gaps && j == 3) begin
          master_valid = 1'b0;
          tx_data      = ~w[k][j];
          cyc();
        end
        master_valid = 1'b1;
        tx_data      = w[k][j];
        cyc();
      end
`ifdef SLAVE_PORT_PARITY_EN
      master_valid = 1'b1;
      tx_data      = (^w[k]) ^ bad_par;
      cyc();
`endif
    end
    quiet();
  endtask

  // Read n words; optional stall at a bit of word 0, optional reset at a bit index.
  task automatic read_words(input string tag, input logic [AW-1:0] a, input int n,
                            input word_arr_t w, input int stall_bit, input int abort_at);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < DW; j++)
        exp_q.push_back(w[k][j]);
    master_ready = 1'b1;
    send_addr(1'b1, a, BW'(n - 1), 1'b0);
    chk({tag, "_fetch_valid"}, {31'd0, slave_valid}, 32'd0);
    chk({tag, "_fetch_ready"}, {31'd0, slave_ready}, 32'd0);
    cyc();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < DW; j++) begin
        if (k * DW + j == abort_at) begin
          rst = 1'b1;
          #1;
          chk({tag, "_rst_ready"}, {31'd0, slave_ready}, 32'd1);
          chk({tag, "_rst_valid"}, {31'd0, slave_valid}, 32'd0);
          chk({tag, "_rst_rx"},    {31'd0, rx_data},     32'd0);
          exp_q.delete();
          cyc();
          rst = 1'b0;
          cyc();
          chk({tag, "_post_rst_ready"}, {31'd0, slave_ready}, 32'd1);
          chk({tag, "_post_rst_valid"}, {31'd0, slave_valid}, 32'd0);
          return;
        end
        chk({tag, "_valid"}, {31'd0, slave_valid}, 32'd1);
        if (k == 0 && j == stall_bit) begin
          master_ready = 1'b0;
          for (int s = 0; s < 3; s++) begin
            chk({tag, "_stall_valid"}, {31'd0, slave_valid}, 32'd1);
            chk({tag, "_stall_rx"},    {31'd0, rx_data},     {31'd0, w[k][j]});
            cyc();
          end
          master_ready = 1'b1;
        end
        cyc();
      end
      if (k < n - 1) begin
        chk({tag, "_gap"}, {31'd0, slave_valid}, 32'd0);
        cyc();
      end
    end
    chk({tag, "_end_valid"}, {31'd0, slave_valid}, 32'd0);
    chk({tag, "_end_ready"}, {31'd0, slave_ready}, 32'd1);
    chk({tag, "_sb_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_arr_t w_a5, w_burst, w_11, w_3c, w_pair, w_0f;
    w_a5    = '{8'hA5, 8'h00, 8'h00, 8'h00};
    w_burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    w_11    = '{8'h11, 8'h00, 8'h00, 8'h00};
    w_3c    = '{8'h3C, 8'h00, 8'h00, 8'h00};
    w_pair  = '{8'hC3, 8'h5A, 8'h00, 8'h00};
    w_0f    = '{8'h0F, 8'h00, 8'h00, 8'h00};

    rst = 1'b1;
    master_ready = 1'b0;
    quiet();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, slave_ready}, 32'd1);
    chk("reset_valid", {31'd0, slave_valid}, 32'd0);
    chk("reset_rx",    {31'd0, rx_data},     32'd0);
    chk("reset_perr",  {31'd0, parity_err},  32'd0);
    rst = 1'b0;
    cyc();

    // Single write then read back with N+2 latency check.
    write_words(11'h123, 1, w_a5, 1'b0, 1'b0);
    chk("wr_idle_ready", {31'd0, slave_ready}, 32'd1);
    read_words("single", 11'h123, 1, w_a5, -1, -1);

    // Burst across the top of the address space.
    write_words(11'h7FE, 4, w_burst, 1'b0, 1'b0);
    read_words("burst", 11'h7FE, 4, w_burst, -1, -1);
    read_words("wrap0", 11'h000, 1, '{8'h33, 8'h00, 8'h00, 8'h00}, -1, -1);

    // Backpressure at bit 4 of 0x11.
    read_words("stall", 11'h7FE, 1, w_11, 4, -1);

    // Illegal starts, then gapped and gap-free writes of the same data.
    master_valid = 1'b1; read_en = 1'b1; write_en = 1'b1;
    tx_address = 1'b1; tx_burst = 1'b1;
    cyc();
    master_valid = 1'b1; read_en = 1'b0; write_en = 1'b0;
    cyc();
    quiet();
    chk("nostart_valid", {31'd0, slave_valid}, 32'd0);
    write_words(11'h2A5, 1, w_3c, 1'b1, 1'b0);
    write_words(11'h15A, 1, w_3c, 1'b0, 1'b0);
    write_words(11'h400, 2, w_pair, 1'b1, 1'b0);
    read_words("gapped", 11'h2A5, 1, w_3c, -1, -1);
    read_words("nogap",  11'h15A, 1, w_3c, -1, -1);
    read_words("gapburst", 11'h400, 2, w_pair, -1, -1);

    // Reset in the middle of word 1 of a burst read, then re-read intact memory.
    read_words("abort", 11'h7FE, 4, w_burst, -1, DW + 3);
    read_words("after_rst", 11'h7FE, 4, w_burst, -1, -1);

`ifdef SLAVE_PORT_PARITY_EN
    write_words(11'h123, 1, w_0f, 1'b0, 1'b1);
    chk("perr_set", {31'd0, parity_err}, 32'd1);
    cyc();
    chk("perr_held", {31'd0, parity_err}, 32'd1);
    read_words("perr_unchanged", 11'h123, 1, w_a5, -1, -1);
    chk("perr_cleared", {31'd0, parity_err}, 32'd0);
    write_words(11'h050, 1, w_0f, 1'b0, 1'b0);
    read_words("par_good", 11'h050, 1, w_0f, -1, -1);
    chk("perr_good", {31'd0, parity_err}, 32'd0);
`else
    write_words(11'h050, 1, w_0f, 1'b0, 1'b0);
    read_words("plain_0f", 11'h050, 1, w_0f, -1, -1);
    chk("perr_tied", {31'd0, parity_err}, 32'd0);
`endif

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
